boot_loader: RTL
================

Name: boot_loader

Overview:
- Memory-bus initiator that copies the boot ROM image into main RAM after reset, or on command.
- Reads each ROM word over the ROM's cs/we/addr/dout responder interface, then writes it to RAM at a configurable base.
- Holds the CPU in stall while copying and reports completion and a 16-bit checksum.
- Sits between the ROM, the RAM and the CPU hold input in the SoC top.

Parameters:
- ROM_AW, 5: ROM address width.
- DW, 16: data word width.
- WORDS, 32: number of words copied; 1..2**ROM_AW.
- RAM_AW, 8: RAM address width.
- RAM_BASE, 0: first RAM address written.
- AUTO_START, 1: when 1, a copy starts automatically after reset.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  single-cycle pulse; starts a copy from IDLE or DONE.
- rom_cs  output  1  ROM chip select.
- rom_we  output  1  ROM write enable; tied 0.
- rom_addr  output  ROM_AW  ROM word address.
- rom_dout  input  DW  ROM read data; valid while rom_cs=1 and rom_we=0.
- ram_cs  output  1  RAM chip select.
- ram_we  output  1  RAM write enable.
- ram_addr  output  RAM_AW  RAM word address.
- ram_din  output  DW  RAM write data.
- ram_busy  input  1  RAM stall; the write is held while high.
- cpu_hold  output  1  stalls the CPU while high.
- done  output  1  level; copy complete.
- checksum  output  DW  wrapping sum of all copied words.

Behaviour:
- Clocking/reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - state=IDLE, word index=0.
  - rom_cs=0, rom_we=0, rom_addr=0.
  - ram_cs=0, ram_we=0, ram_addr=0, ram_din=0.
  - done=0, checksum=0.
  - cpu_hold=AUTO_START.
- States: IDLE, RD, CAP, WR, DONE.
- IDLE:
  - -> RD with index=0 and checksum cleared, on start=1, or on the first cycle after reset when AUTO_START=1.
  - cpu_hold=1 from that transition edge onward.
- RD:
  - rom_cs=1, rom_addr=index. Always -> CAP.
- CAP:
  - rom_cs remains 1. Register rom_dout into ram_din.
  - checksum += rom_dout, modulo 2**DW.
  - -> WR.
- WR:
  - rom_cs=0, ram_cs=1, ram_we=1, ram_addr=RAM_BASE+index (modulo 2**RAM_AW).
  - If ram_busy=1: stay in WR; ram_cs, ram_we, ram_addr and ram_din held stable.
  - If ram_busy=0: if index==WORDS-1 -> DONE, else index++ and -> RD.
- DONE:
  - ram_cs=0, ram_we=0, done=1, cpu_hold=0.
  - start=1 -> RD; done and checksum clear on that edge.
- Latency: 3 cycles per word with no stall. With AUTO_START=1, done rises after the (3·WORDS+1)th edge following rst deassertion; 97 edges for the defaults.
- start pulses in RD, CAP or WR are ignored.
- rst asserted mid-copy: the copy aborts in the same cycle, all outputs return to their reset values, and a restarted copy begins at word 0.
- Simultaneous start and rst: rst wins.
- ram_busy is ignored outside WR.
- rom_we is never 1, so the ROM output latch always tracks addr while rom_cs=1.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RD, CAP, WR, DONE);
  - the default constants ROM_AW, DW and RAM_AW, so they match the ROM and RAM blocks.
- No sub-module is needed.
- Optional: the checksum adder may be a small sub-module, boot_cksum, for reuse by a future verify pass.

Test Plan:
- Auto boot with the standard ROM image and ram_busy=0:
  - cpu_hold=1 from reset.
  - 32 RAM writes: addr 0x00 data 0xF200, addr 0x01 data 0x4000, …, addr 0x1F data 0xC01E.
  - done=1 after edge 97.
  - checksum=0x845A; cpu_hold=0.
- RAM stall: ram_busy=1 for 4 cycles during the WR of word 5.
  - ram_addr=0x05 and ram_din=0x3090 stable throughout the stall.
  - No extra write occurs; done is delayed by exactly 4 cycles.
- Restart: start pulse in DONE.
  - done falls on the next edge.
  - The full copy repeats with an identical RAM image and checksum 0x845A.
- Mid-copy reset: rst asserted in the WR of word 10.
  - All outputs return to reset values the next cycle.
  - Copy restarts at ROM addr 0; the final checksum is still 0x845A.
- Parameter variant: RAM_BASE=0xF0, WORDS=32.
  - RAM addresses 0xF0..0xFF, then wrap to 0x00..0x0F.
  - Ignored start pulses mid-copy cause no change in the sequence.
- Protocol check throughout: rom_we=0 always, rom_cs and ram_cs are never high in the same cycle, and ram_we=1 only when ram_cs=1.

Source files
------------

// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM state encoding and the default
// bus widths that match the boot ROM and main RAM blocks.
package boot_loader_pkg;

    localparam int ROM_AW_DEF = 5;
    localparam int DW_DEF     = 16;
    localparam int RAM_AW_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        DONE
    } boot_state_t;

endpackage

// File: rtl/boot_loader.sv
// Boot loader: copies WORDS words from the boot ROM into RAM starting at
// RAM_BASE, holding the CPU until the copy completes and reporting a checksum.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int ROM_AW     = ROM_AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int WORDS      = 32,
    parameter int RAM_AW     = RAM_AW_DEF,
    parameter int RAM_BASE   = 0,
    parameter bit AUTO_START = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rom_cs,
    output logic              rom_we,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [DW-1:0]     rom_dout,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DW-1:0]     ram_din,
    input  logic              ram_busy,
    output logic              cpu_hold,
    output logic              done,
    output logic [DW-1:0]     checksum
);

    localparam logic [ROM_AW-1:0] LAST_IDX  = ROM_AW'(WORDS - 1);
    localparam logic [RAM_AW-1:0] BASE_ADDR = RAM_AW'(RAM_BASE);

    // Wrapping modulo-2**DW accumulate for the image checksum.
    function automatic logic [DW-1:0] wrap_add(input logic [DW-1:0] acc,
                                               input logic [DW-1:0] word);
        return acc + word;
    endfunction

    boot_state_t       state, state_n;
    logic [ROM_AW-1:0] index, index_n;
    logic [DW-1:0]     ram_din_n;
    logic [DW-1:0]     checksum_n;
    logic              auto_pend, auto_pend_n;

    // The ROM is read-only from here; keeping we low lets its latch track addr.
    assign rom_we = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            index     <= '0;
            ram_din   <= '0;
            checksum  <= '0;
            auto_pend <= AUTO_START;
        end else begin
            state     <= state_n;
            index     <= index_n;
            ram_din   <= ram_din_n;
            checksum  <= checksum_n;
            auto_pend <= auto_pend_n;
        end
    end

    always_comb begin
        state_n     = state;
        index_n     = index;
        ram_din_n   = ram_din;
        checksum_n  = checksum;
        auto_pend_n = auto_pend;
        rom_cs      = 1'b0;
        rom_addr    = '0;
        ram_cs      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        done        = 1'b0;
        cpu_hold    = 1'b1;

        case (state)
            IDLE: begin
                // auto_pend keeps the CPU held across the single post-reset cycle
                cpu_hold = auto_pend;
                if (start || auto_pend) begin
                    state_n     = RD;
                    index_n     = '0;
                    checksum_n  = '0;
                    auto_pend_n = 1'b0;
                end
            end
            RD: begin
                rom_cs   = 1'b1;
                rom_addr = index;
                state_n  = CAP;
            end
            CAP: begin
                rom_cs     = 1'b1;
                rom_addr   = index;
                ram_din_n  = rom_dout;
                checksum_n = wrap_add(checksum, rom_dout);
                state_n    = WR;
            end
            WR: begin
                ram_cs   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = BASE_ADDR + RAM_AW'(index);
                if (!ram_busy) begin
                    if (index == LAST_IDX) begin
                        state_n = DONE;
                    end else begin
                        index_n = index + ROM_AW'(1);
                        state_n = RD;
                    end
                end
            end
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) begin
                    state_n    = RD;
                    index_n    = '0;
                    checksum_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
